// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional misaligned-PC trapping is enabled with `IFETCH_MISALIGN_EN.
package ifetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            err;
  } fetch_word_t;

endpackage

// File: rtl/ifetch_if.sv
// Instruction-memory request/response channels plus the decode-side output channel.
interface ifetch_if;
  import ifetch_pkg::*;

  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;

  logic            imem_rsp_valid;
  logic            imem_rsp_ready;
  logic [XLEN-1:0] imem_rsp_data;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic            out_err;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output imem_rsp_ready,
    output out_valid, out_instr, out_pc, out_err,
    input  out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  imem_rsp_ready,
    input  out_valid, out_instr, out_pc, out_err,
    output out_ready
  );

endinterface

// File: rtl/ifetch_out_buf.sv
// Single-entry output register toward decode with valid/ready handshake.
// Flush empties the entry; a capture wins over a simultaneous drain.
module ifetch_out_buf
  import ifetch_pkg::*;
#(
  parameter bit ERR_EN = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_i,
  input  logic            cap_valid_i,
  input  fetch_word_t     cap_i,
  input  logic            out_ready_i,
  output logic            out_valid_o,
  output logic [XLEN-1:0] out_instr_o,
  output logic [XLEN-1:0] out_pc_o,
  output logic            out_err_o,
  output logic            free_o
);

  logic        valid_q, valid_d;
  fetch_word_t word_q, word_d;

  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (cap_valid_i) begin
      valid_d = 1'b1;
      word_d  = cap_i;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      word_q  <= '{instr: NOP_INSTR, pc: '0, err: 1'b0};
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
    end
  end

  assign free_o      = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_instr_o = word_q.instr;
  assign out_pc_o    = word_q.pc;
  assign out_err_o   = ERR_EN ? word_q.err : 1'b0;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch FSM: one outstanding imem request, PC hold/advance control,
// flush handling with response drop. `IFETCH_MISALIGN_EN traps misaligned PCs.
module ifetch_unit
  import ifetch_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  output logic            stop,
  ifetch_if.master        bus
);

`ifdef IFETCH_MISALIGN_EN
  localparam bit MISALIGN_EN = 1'b1;
`else
  localparam bit MISALIGN_EN = 1'b0;
`endif

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;

  logic        req_valid;
  logic        rsp_ready;
  logic        cap_valid;
  fetch_word_t cap;
  logic        buf_free;
  logic        misaligned;
  logic        advance;

  assign misaligned = MISALIGN_EN && (pc[1:0] != 2'b00);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    cap_valid = 1'b0;
    cap       = '{instr: bus.imem_rsp_data, pc: pc_q, err: 1'b0};

    case (state_q)
      IDLE: state_d = REQ;

      REQ: begin
        if (misaligned) begin
          if (!flush && buf_free) begin
            cap_valid = 1'b1;
            cap       = '{instr: NOP_INSTR, pc: pc, err: 1'b1};
          end
        end else begin
          req_valid = 1'b1;
          if (bus.imem_req_ready) begin
            pc_d    = pc;
            state_d = flush ? DROP : WAIT;
          end
        end
      end

      WAIT: begin
        rsp_ready = buf_free;
        // A response consumed on the flush cycle retires the request, so no DROP is needed.
        if (bus.imem_rsp_valid && buf_free) begin
          cap_valid = !flush;
          state_d   = REQ;
        end else if (flush) begin
          state_d = DROP;
        end
      end

      DROP: begin
        rsp_ready = 1'b1;
        // Only the response retires the stale request; a new flush just keeps waiting.
        if (bus.imem_rsp_valid) state_d = REQ;
      end

      default: state_d = IDLE;
    endcase

    if (reset) begin
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      cap_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign advance            = cap_valid;
  assign stop               = reset || !(advance || flush);
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc;
  assign bus.imem_rsp_ready = rsp_ready;

  ifetch_out_buf #(
    .ERR_EN (MISALIGN_EN)
  ) u_out_buf (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush),
    .cap_valid_i (cap_valid),
    .cap_i       (cap),
    .out_ready_i (bus.out_ready),
    .out_valid_o (bus.out_valid),
    .out_instr_o (bus.out_instr),
    .out_pc_o    (bus.out_pc),
    .out_err_o   (bus.out_err),
    .free_o      (buf_free)
  );

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have `clk`, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-002 SHALL have `reset`, input, 1 bit, synchronous and active-high.
REQ-003 SHALL have `pc`, input, 32 bits, the current fetch address from the PC register.
REQ-004 SHALL have `stop`, output, 1 bit, a hold request to the PC register (1 = hold PC, 0 = PC loads its next value).
REQ-005 SHALL have `flush`, input, 1 bit, a redirect pulse; the PC loads the redirect target on the same edge.
REQ-006 SHALL have the imem request ports: `imem_req_valid` out 1, `imem_req_addr` out 32, `imem_req_ready` in 1.
REQ-007 SHALL have the imem response ports: `imem_rsp_valid` in 1, `imem_rsp_ready` out 1, `imem_rsp_data` in 32.
REQ-008 SHALL have the decode ports: `out_valid` out 1, `out_ready` in 1, `out_instr` out 32, `out_pc` out 32, `out_err` out 1.

Function
REQ-009 SHALL implement FSM states IDLE, REQ, WAIT and DROP.
REQ-010 IDLE SHALL move to REQ unconditionally after one cycle.
REQ-011 In REQ, `imem_req_valid`=1 and `imem_req_addr`=`pc`.
REQ-012 In REQ, a cycle with `imem_req_ready`=1 SHALL latch `pc` into `pc_q` and go to WAIT.
REQ-013 In WAIT, `imem_rsp_ready` SHALL equal (!`out_valid` || `out_ready`).
REQ-014 In WAIT, a response handshake SHALL load `out_instr`=`imem_rsp_data`, `out_pc`=`pc_q`, `out_err`=0 and `out_valid`=1, pulse `advance` for one cycle, and go to REQ.
REQ-015 `stop` SHALL equal !(`advance` || `flush`), so the PC moves only on an accepted fetch or a redirect; the next REQ cycle presents the updated `pc`.
REQ-016 When `out_valid`=1, `out_ready`=1 and no new capture occurs, `out_valid` SHALL clear the next cycle; `out_*` SHALL hold stable while `out_valid`=1 and `out_ready`=0.
REQ-017 `flush` SHALL clear `out_valid` the next cycle, with no capture on the flush cycle.
REQ-018 `flush` in WAIT, or in REQ with the request handshake completing, SHALL go to DROP; otherwise it SHALL go to REQ.
REQ-019 In DROP, `imem_rsp_ready`=1, and the next response SHALL be discarded, followed by a move to REQ; only one request SHALL be outstanding at any time.
REQ-020 `flush` in DROP SHALL remain in DROP.
REQ-021 `flush` SHALL take priority over a simultaneous response capture.

Reset
REQ-022 `reset`=1 SHALL force state=IDLE, `out_valid`=0, `out_err`=0, `out_instr`=32'h00000013, `out_pc`=0, `pc_q`=0, `advance`=0.
REQ-023 During reset, `stop`=1, `imem_req_valid`=0 and `imem_rsp_ready`=0.
REQ-024 Reset mid-transaction SHALL abandon the outstanding request; the imem side is reset in the same cycle.

Configuration
REQ-025 With `IFETCH_MISALIGN_EN` defined, REQ with `pc[1:0]`!=0 SHALL issue no request.
REQ-026 Under `IFETCH_MISALIGN_EN`, it SHALL instead capture `out_instr`=NOP (32'h00000013), `out_pc`=`pc`, `out_err`=1, pulse `advance`, and stay in REQ, subject to the buffer-free rule of REQ-013.
REQ-027 Without `IFETCH_MISALIGN_EN`, `pc[1:0]` SHALL be passed through unchecked and `out_err` SHALL be tied to 0.

Structure
REQ-028 Shared package `ifetch_pkg` SHALL hold the FSM state enum, NOP_INSTR=32'h00000013 and XLEN=32.
REQ-029 The output register and its valid/ready logic SHALL be the sub-module `ifetch_out_buf`.

Verification
REQ-030 Reset: assert `reset` for 2 cycles -> `out_valid`=0, `stop`=1, `imem_req_valid`=0; IDLE→REQ one cycle after release.
REQ-031 Basic fetch: `pc`=0x100, ready=1, response 0x00500093 one cycle later, `out_ready`=1 -> `out_instr`=0x00500093, `out_pc`=0x100, one-cycle `stop`=0.
REQ-032 Backpressure: `out_ready`=0 with `out_valid`=1 -> `imem_rsp_ready`=0 in WAIT, outputs stable, `stop`=1 until drained.
REQ-033 Flush in WAIT: `flush` while a response is pending for 0x104 -> response discarded, `out_valid` stays 0, next request uses the new `pc`=0x200.
REQ-034 Misaligned (`IFETCH_MISALIGN_EN`): `pc`=0x102 -> no `imem_req_valid`, `out_err`=1, `out_instr`=0x00000013, `out_pc`=0x102.
REQ-035 Simultaneous events: `flush` on the same cycle as `imem_rsp_valid` -> no capture, `stop`=0, state=REQ.
